// File: rtl/hex_display_pkg.sv
// ============================================================================
// hex_display_pkg : shared FSM states, blank code and 7-segment table
// Revision: 1.0
// ============================================================================
`default_nettype none

package hex_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments, bit0 = a ... bit6 = g, indexed by nibble value.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

`default_nettype wire

// File: rtl/hex_seg_decode.sv
// ============================================================================
// hex_seg_decode : combinational nibble to active-low 7-segment decoder
// Revision: 1.0
// ============================================================================
`default_nettype none

module hex_seg_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

`default_nettype wire

// File: rtl/hex_display_bank.sv
// ============================================================================
// hex_display_bank : multi-digit hex display with scan/commit update,
// leading-zero blanking, per-digit enable and blink (HEX_DISPLAY_BLINK_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module hex_display_bank
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_t                  state;
    state_t                  state_next;
    logic [IDX_W-1:0]        scan_idx;
    logic [4*NUM_DIGITS-1:0] load_q;
    logic                    lz_q;
    logic                    seen_nonzero;
    logic [3:0]              cur_nibble;
    logic [6:0]              dec_seg;
    logic [6:0]              scan_seg;
    logic                    accept;
    logic                    blink_phase;
    logic [6:0]              shadow  [NUM_DIGITS];
    logic [6:0]              display [NUM_DIGITS];

    assign load_ready = (state == ST_IDLE);
    assign accept     = load_ready && load_valid;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (load_valid) state_next = ST_SCAN;
            ST_SCAN:   if (scan_idx == '0) state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Scan runs MSB first so leading-zero state is known when each digit is written.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            scan_idx     <= '0;
            load_q       <= '0;
            lz_q         <= 1'b0;
            seen_nonzero <= 1'b0;
        end else if (accept) begin
            scan_idx     <= IDX_W'(NUM_DIGITS - 1);
            load_q       <= load_data;
            lz_q         <= blank_lz;
            seen_nonzero <= 1'b0;
        end else if (state == ST_SCAN) begin
            seen_nonzero <= seen_nonzero | (cur_nibble != 4'd0);
            if (scan_idx != '0) begin
                scan_idx <= scan_idx - 1'b1;
            end
        end
    end

    always_comb begin
        cur_nibble = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                cur_nibble = load_q[4*i +: 4];
            end
        end
    end

    hex_seg_decode u_decode (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        scan_seg = dec_seg;
        if (lz_q && !seen_nonzero && (cur_nibble == 4'd0) && (scan_idx != '0)) begin
            scan_seg = SEG_BLANK;
        end
    end

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            localparam logic [IDX_W-1:0] DIGIT_IDX = IDX_W'(i);

            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    shadow[i]  <= SEG_BLANK;
                    display[i] <= SEG_BLANK;
                end else begin
                    if ((state == ST_SCAN) && (scan_idx == DIGIT_IDX)) begin
                        shadow[i] <= scan_seg;
                    end
                    if (state == ST_COMMIT) begin
                        display[i] <= shadow[i];
                    end
                end
            end

            assign hex_out[7*i +: 7] = (!digit_en[i] || (blink_phase && blink_mask[i]))
                                       ? SEG_BLANK : display[i];
        end
    endgenerate

`ifdef HEX_DISPLAY_BLINK_EN
    localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0] blink_cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end
`else
    logic unused_blink_cfg;

    assign blink_phase      = 1'b0;
    assign unused_blink_cfg = (BLINK_DIV < 2);
`endif

endmodule

`default_nettype wire

// File: tb/tb_hex_display_bank.sv
// ============================================================================
// tb_hex_display_bank : randomized self-checking bench against a digit-level
// reference model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hex_display_bank;

    localparam int N     = 6;
    localparam int BLINK = 4;

    logic          clock = 1'b0;
    logic          resetn;
    logic          load_valid;
    logic          load_ready;
    logic [4*N-1:0] load_data;
    logic          blank_lz;
    logic [N-1:0]  digit_en;
    logic [N-1:0]  blink_mask;
    logic [7*N-1:0] hex_out;

    int errors = 0;
    int checks = 0;
    int edges  = 0;

    logic [23:0] shown_val;
    bit          shown_lz;
    bit          shown_valid;

    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    always #5 clock = ~clock;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) edges <= 0;
        else         edges <= edges + 1;
    end

    hex_display_bank #(.NUM_DIGITS(N), .BLINK_DIV(BLINK)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .blank_lz   (blank_lz),
        .digit_en   (digit_en),
        .blink_mask (blink_mask),
        .hex_out    (hex_out)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7*N-1:0] model_hex(input logic [23:0] val, input bit lz,
                                                 input bit valid, input logic [N-1:0] en,
                                                 input logic [N-1:0] bm, input bit ph);
        logic [7*N-1:0] r;
        logic [6:0]     s;
        logic [3:0]     nib;
        int             msd = 0;
        for (int i = 0; i < N; i++) if (val[4*i +: 4] != 4'd0) msd = i;
        for (int i = 0; i < N; i++) begin
            nib = val[4*i +: 4];
            s   = valid ? seg_tab[nib] : 7'h7F;
            if (lz && i > msd) s = 7'h7F;
            if (!en[i] || (ph && bm[i])) s = 7'h7F;
            r[7*i +: 7] = s;
        end
        return r;
    endfunction

    function automatic bit model_phase();
`ifdef HEX_DISPLAY_BLINK_EN
        return ((edges / BLINK) % 2) == 1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7*N-1:0] cur_expect();
        return model_hex(shown_val, shown_lz, shown_valid, digit_en, blink_mask, model_phase());
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer a value, optionally poke load_valid again mid-scan, and follow it to commit.
    task automatic do_load(input logic [23:0] val, input bit lz, input bit intrude);
        load_data  = val;
        blank_lz   = lz;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int k = 1; k <= N + 1; k++) begin
            if (intrude && k == 2) begin
                load_valid = 1'b1;
                load_data  = ~val;
                blank_lz   = ~lz;
            end
            tick();
            load_valid = 1'b0;
            if (k <= N) begin
                check_val("hold_old", hex_out, cur_expect());
                check_val("ready_low", load_ready, 1'b0);
            end else begin
                shown_val   = val;
                shown_lz    = lz;
                shown_valid = 1'b1;
                check_val("show_new", hex_out, cur_expect());
                check_val("ready_high", load_ready, 1'b1);
            end
        end
        tick();
        check_val("stay_first", hex_out, cur_expect());
    endtask

    initial begin
        logic [23:0] rval;
        resetn      = 1'b0;
        load_valid  = 1'b0;
        load_data   = '0;
        blank_lz    = 1'b0;
        digit_en    = '1;
        blink_mask  = '0;
        shown_val   = '0;
        shown_lz    = 1'b0;
        shown_valid = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
        check_val("reset_hex", hex_out, {7*N{1'b1}});
        check_val("reset_ready", load_ready, 1'b1);

        do_load(24'h0012AF, 1'b0, 1'b0);
        check_val("dir_12AF", hex_out, {7'h40, 7'h40, 7'h79, 7'h24, 7'h08, 7'h0E});
        do_load(24'h000300, 1'b1, 1'b0);
        check_val("dir_lz_300", hex_out, {7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40, 7'h40});
        do_load(24'h000000, 1'b1, 1'b0);
        check_val("dir_lz_zero", hex_out, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});

        do_load(24'h00ABCD, 1'b0, 1'b1);
        check_val("dir_intrude", hex_out, {7'h40, 7'h40, 7'h08, 7'h03, 7'h46, 7'h21});

        for (int it = 0; it < 12; it++) begin
            rval     = 24'($urandom) & (24'hFFFFFF >> (4 * $urandom_range(0, 5)));
            digit_en = ($urandom_range(0, 2) == 0) ? N'($urandom) : '1;
            do_load(rval, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        for (int it = 0; it < 4; it++) begin
            digit_en = N'($urandom);
            #1;
            check_val("live_enable", hex_out, cur_expect());
        end
        digit_en = '1;

        do_load(24'h123456, 1'b0, 1'b0);
        blink_mask = 6'b000001;
        for (int k = 0; k < 16; k++) begin
            tick();
            check_val("blink_d0", hex_out, cur_expect());
        end
        blink_mask = '0;

        load_data  = 24'h987654;
        blank_lz   = 1'b0;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        tick();
        tick();
        resetn = 1'b0;
        #2;
        check_val("abort_async_hex", hex_out, {7*N{1'b1}});
        shown_valid = 1'b0;
        resetn = 1'b1;
        tick();
        check_val("abort_ready", load_ready, 1'b1);
        for (int k = 0; k < N + 3; k++) begin
            check_val("abort_blank", hex_out, {7*N{1'b1}});
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hex_display_bank.md
HEX_DISPLAY_BANK -- requirements
Module: hex_display_bank

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of 7-segment digits driven (1..8).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, clock cycles per blink half-period (>=2).
REQ-003 SHALL have port clock  input  1  rising-edge system clock.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port load_valid  input  1  new display value offered.
REQ-006 SHALL have port load_ready  output  1  block can accept a value.
REQ-007 SHALL have port load_data  input  4*NUM_DIGITS  hex nibbles; nibble i drives digit i; digit 0 is LSB.
REQ-008 SHALL have port blank_lz  input  1  leading-zero blanking enable, sampled with load_data.
REQ-009 SHALL have port digit_en  input  NUM_DIGITS  per-digit live enable; 0 blanks that digit.
REQ-010 SHALL have port blink_mask  input  NUM_DIGITS  per-digit live blink select.
REQ-011 SHALL have port hex_out  output  7*NUM_DIGITS  active-low segments; bits [7i+6:7i] = digit i, bit0 = seg a ... bit6 = seg g.

Function
REQ-012 SHALL accept a load on a rising edge with load_valid=1 and load_ready=1, capturing load_data and blank_lz.
REQ-013 SHALL implement states IDLE, SCAN, COMMIT: IDLE->SCAN on accept; SCAN->COMMIT after the scan of digit 0; COMMIT->IDLE after one cycle.
REQ-014 SHALL drive load_ready=1 only in IDLE; load_valid outside IDLE is ignored, not queued.
REQ-015 SHALL scan one digit per cycle from NUM_DIGITS-1 down to 0 through a single shared decoder, writing a shadow register.
REQ-016 SHALL decode nibbles active-low: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=18 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-017 SHALL, with blank_lz=1, write 7F for each zero digit above the most significant nonzero digit; digit 0 is never blanked by this rule.
REQ-018 SHALL copy the shadow register to the display register in COMMIT, so hex_out never shows a mixture of old and new values.
REQ-019 SHALL show a new value on hex_out NUM_DIGITS+1 cycles after the accepting edge; load_ready returns high on the same edge.
REQ-020 SHALL output 7F for digit i, combinationally, when digit_en[i]=0 or (blink_phase=1 and blink_mask[i]=1); otherwise the display register.
REQ-021 SHALL keep the blink counter and blink_phase free-running and independent of loads.

Reset
REQ-022 SHALL on resetn=0 asynchronously force state IDLE, the scan index, display and shadow registers (all 7F), the blink counter and blink_phase to 0.
REQ-023 SHALL abort a load in progress when reset asserts mid-SCAN or mid-COMMIT; the display stays blank and load_ready=1 after release.

Configuration
REQ-024 SHALL, with HEX_DISPLAY_BLINK_EN defined, implement a counter that toggles blink_phase every BLINK_DIV cycles.
REQ-025 SHALL, without HEX_DISPLAY_BLINK_EN, omit the counter, tie blink_phase to 0 and ignore blink_mask.

Structure
REQ-026 SHALL place the state enum, the SEG_BLANK=7'h7F constant and the 16-entry segment table in shared package hex_display_pkg.
REQ-027 SHALL implement the decoder as sub-module hex_seg_decode (4-bit in, 7-bit active-low out, purely combinational).

Verification
REQ-028 SHALL verify: after reset -> hex_out all 1s, load_ready=1.
REQ-029 SHALL verify: NUM_DIGITS=6, load 0x0012AF, blank_lz=0 -> after 7 cycles digits 5..0 = 40,40,79,24,08,0E.
REQ-030 SHALL verify: load 0x000300, blank_lz=1 -> digits 5..3 = 7F, digits 2..0 = 30,40,40; load 0 -> only digit 0 = 40.
REQ-031 SHALL verify: a second load_valid during SCAN -> ignored; hex_out holds old value until COMMIT, then shows the first value only.
REQ-032 SHALL verify: BLINK_DIV=4 with macro, blink_mask=000001 -> digit 0 alternates every 4 cycles; without macro -> steady.
REQ-033 SHALL verify: resetn pulsed at SCAN cycle 3 -> hex_out stays 7F everywhere, load_ready=1 after release.
